// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: forwarding, load-use/RAW stalls, redirect flushes, divide sequencer
// Optional feature macro: HAZARD_FORWARDING_EN (operand forwarding; without it RAW hazards stall)
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       ResultSrcE0,
    input  logic       PCSrcE,
    input  logic       DivStartE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       DivBusy,
    output logic       DivDone
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic             hz_stall;

    // True when a Decode source register depends on a pending write to rd.
    function automatic logic dep_d(input logic [4:0] rd, input logic we,
                                   input logic [4:0] rs1, input logic [4:0] rs2);
        return we && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

`ifdef HAZARD_FORWARDING_EN
    // Memory stage wins over Writeback because it holds the younger value.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic we_m,
                                           input logic [4:0] rd_w, input logic we_w);
        if (rs != 5'd0 && rs == rd_m && we_m)
            return 2'b10;
        else if (rs != 5'd0 && rs == rd_w && we_w)
            return 2'b01;
        return 2'b00;
    endfunction

    logic unused_cfg;

    assign ForwardAE  = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE  = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    assign hz_stall   = dep_d(RdE, ResultSrcE0, Rs1D, Rs2D);
    assign unused_cfg = RegWriteE;
`else
    logic unused_cfg;

    assign ForwardAE  = 2'b00;
    assign ForwardBE  = 2'b00;
    // Writeback is absent: the register file writes before it reads.
    assign hz_stall   = dep_d(RdE, RegWriteE, Rs1D, Rs2D) | dep_d(RdM, RegWriteM, Rs1D, Rs2D);
    assign unused_cfg = ^{Rs1E, Rs2E, RdW, RegWriteW, ResultSrcE0};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (DivStartE && !PCSrcE) begin
                        state  <= S_BUSY;
                        cnt    <= CNT_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                // The finished divide still sits in Execute, so a DivStartE here is not a new op.
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign DivBusy = busy_q;
    assign DivDone = done_q;

    // Hazard terms are combinational, so they are gated by reset to keep the pipeline quiet.
    assign StallF = reset & (hz_stall | busy_q);
    assign StallD = reset & (hz_stall | busy_q);
    assign StallE = busy_q;
    assign FlushM = busy_q;
    assign FlushD = reset & PCSrcE & ~busy_q;
    assign FlushE = reset & (hz_stall | PCSrcE) & ~busy_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl (DIV_CYCLES=4)
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Control byte order: StallF StallD StallE FlushD FlushE FlushM DivBusy DivDone
    localparam logic [7:0] C_NONE   = 8'b0000_0000;
    localparam logic [7:0] C_BUSY   = 8'b1110_0110;
    localparam logic [7:0] C_DONE   = 8'b0000_0001;
    localparam logic [7:0] C_HAZ    = 8'b1100_1000;
    localparam logic [7:0] C_BR     = 8'b0001_1000;
    localparam logic [7:0] C_BR_HAZ = 8'b1101_1000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, DivStartE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, DivBusy, DivDone;
    logic [11:0] act;

    int checks = 0;
    int errors = 0;
    logic [11:0] sb_v[$];
    string       sb_n[$];

    hazard_ctrl #(.DIV_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .DivStartE(DivStartE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .DivBusy(DivBusy), .DivDone(DivDone)
    );

    always #5 clk = ~clk;

    assign act = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, DivBusy, DivDone};

    function automatic logic [11:0] pk(input logic [1:0] fa, input logic [1:0] fb, input logic [7:0] c);
        return {fa, fb, c};
    endfunction

    task automatic push(input string n, input logic [11:0] v);
        sb_n.push_back(n);
        sb_v.push_back(v);
    endtask

    task automatic clr_in();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0; PCSrcE = 0; DivStartE = 0;
    endtask

    task automatic test_reset();
        logic [11:0] ev; string en;
        clr_in();
        ResultSrcE0 = 1; RegWriteE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
        Rs1E = 5; RdM = 5; RegWriteM = 1;
        push("reset_outputs", pk(FWD ? 2'b10 : 2'b00, 2'b00, C_NONE));
        @(negedge clk);
        ev = sb_v.pop_front(); en = sb_n.pop_front(); checks++;
        if (act !== ev) begin errors++; $display("FAIL %s: got %b expected %b", en, act, ev); end
        #2; clr_in(); reset = 1'b1;
        push("after_reset_idle", pk(2'b00, 2'b00, C_NONE));
        @(negedge clk);
        ev = sb_v.pop_front(); en = sb_n.pop_front(); checks++;
        if (act !== ev) begin errors++; $display("FAIL %s: got %b expected %b", en, act, ev); end
    endtask

    task automatic test_forwarding();
        logic [11:0] ev; string en;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1; clr_in();
            case (i)
                0: begin Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
                         push("fwd_mem_priority", pk(FWD ? 2'b10 : 2'b00, 2'b00, C_NONE)); end
                1: begin Rs1E = 5; RdM = 5; RdW = 5; RegWriteW = 1;
                         push("fwd_wb", pk(FWD ? 2'b01 : 2'b00, 2'b00, C_NONE)); end
                2: begin RdM = 0; RegWriteM = 1; RdW = 0; RegWriteW = 1;
                         push("fwd_x0", pk(2'b00, 2'b00, C_NONE)); end
                3: begin Rs1E = 3; RdM = 3; RegWriteM = 1; Rs2E = 9; RdW = 9; RegWriteW = 1;
                         push("fwd_a_mem_b_wb", pk(FWD ? 2'b10 : 2'b00, FWD ? 2'b01 : 2'b00, C_NONE)); end
                4: begin Rs1E = 9; RdM = 3; RegWriteM = 1; Rs2E = 3; RdW = 9; RegWriteW = 1;
                         push("fwd_a_wb_b_mem", pk(FWD ? 2'b01 : 2'b00, FWD ? 2'b10 : 2'b00, C_NONE)); end
                default: begin Rs1E = 4; RdM = 4; RdW = 4;
                         push("fwd_no_write", pk(2'b00, 2'b00, C_NONE)); end
            endcase
            @(negedge clk);
            ev = sb_v.pop_front(); en = sb_n.pop_front(); checks++;
            if (act !== ev) begin errors++; $display("FAIL %s: got %b expected %b", en, act, ev); end
        end
    endtask

    task automatic test_load_use();
        logic [11:0] ev; string en;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; clr_in();
            case (i)
                0: begin ResultSrcE0 = 1; RegWriteE = 1; RdE = 7; Rs2D = 7;
                         push("lu_rs2", pk(2'b00, 2'b00, C_HAZ)); end
                1: push("lu_released", pk(2'b00, 2'b00, C_NONE));
                2: begin ResultSrcE0 = 1; RegWriteE = 1; RdE = 0; Rs2D = 0;
                         push("lu_x0", pk(2'b00, 2'b00, C_NONE)); end
                default: begin ResultSrcE0 = 1; RegWriteE = 1; RdE = 12; Rs1D = 12; Rs2D = 1;
                         push("lu_rs1", pk(2'b00, 2'b00, C_HAZ)); end
            endcase
            @(negedge clk);
            ev = sb_v.pop_front(); en = sb_n.pop_front(); checks++;
            if (act !== ev) begin errors++; $display("FAIL %s: got %b expected %b", en, act, ev); end
        end
    endtask

    task automatic test_raw_stall();
        logic [11:0] ev; string en;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; clr_in();
            case (i)
                0: begin RegWriteM = 1; RdM = 3; Rs1D = 3;
                         push("raw_mem", pk(2'b00, 2'b00, FWD ? C_NONE : C_HAZ)); end
                1: begin RegWriteE = 1; RdE = 4; Rs2D = 4;
                         push("raw_exe", pk(2'b00, 2'b00, FWD ? C_NONE : C_HAZ)); end
                2: begin RegWriteW = 1; RdW = 6; Rs1D = 6;
                         push("raw_wb_no_stall", pk(2'b00, 2'b00, C_NONE)); end
                3: begin RegWriteM = 1; RdM = 0; Rs1D = 0;
                         push("raw_x0", pk(2'b00, 2'b00, C_NONE)); end
                default: begin RdM = 3; Rs1D = 3;
                         push("raw_no_write", pk(2'b00, 2'b00, C_NONE)); end
            endcase
            @(negedge clk);
            ev = sb_v.pop_front(); en = sb_n.pop_front(); checks++;
            if (act !== ev) begin errors++; $display("FAIL %s: got %b expected %b", en, act, ev); end
        end
    endtask

    task automatic test_branch();
        logic [11:0] ev; string en;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1; clr_in(); PCSrcE = 1;
            if (i == 0) push("br_flush", pk(2'b00, 2'b00, C_BR));
            else begin
                ResultSrcE0 = 1; RegWriteE = 1; RdE = 7; Rs2D = 7;
                push("br_with_load_use", pk(2'b00, 2'b00, C_BR_HAZ));
            end
            @(negedge clk);
            ev = sb_v.pop_front(); en = sb_n.pop_front(); checks++;
            if (act !== ev) begin errors++; $display("FAIL %s: got %b expected %b", en, act, ev); end
        end
    endtask

    // DivStartE held high through cycle 5: second divide issues from IDLE in cycle 5.
    task automatic test_back_to_back();
        logic [11:0] ev; string en;
        logic [7:0] seq [11] = '{C_NONE, C_BUSY, C_BUSY, C_BUSY, C_DONE, C_NONE,
                                 C_BUSY, C_BUSY, C_BUSY, C_DONE, C_NONE};
        for (int i = 0; i < 11; i++) push($sformatf("div_b2b_c%0d", i), pk(2'b00, 2'b00, seq[i]));
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1; clr_in(); DivStartE = (i <= 5);
            @(negedge clk);
            ev = sb_v.pop_front(); en = sb_n.pop_front(); checks++;
            if (act !== ev) begin errors++; $display("FAIL %s: got %b expected %b", en, act, ev); end
        end
    endtask

    task automatic test_div_hazards();
        logic [11:0] ev; string en;
        logic [7:0] seq [7] = '{C_NONE, C_BUSY, C_BUSY, C_BUSY, C_DONE, C_BR, C_NONE};
        for (int i = 0; i < 7; i++) push($sformatf("div_haz_c%0d", i), pk(2'b00, 2'b00, seq[i]));
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1; clr_in();
            if (i == 0) DivStartE = 1;
            if (i == 1) begin PCSrcE = 1; ResultSrcE0 = 1; RegWriteE = 1; RdE = 7; Rs1D = 7; end
            if (i == 5) begin DivStartE = 1; PCSrcE = 1; end
            @(negedge clk);
            ev = sb_v.pop_front(); en = sb_n.pop_front(); checks++;
            if (act !== ev) begin errors++; $display("FAIL %s: got %b expected %b", en, act, ev); end
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] ev; string en;
        logic [7:0] seq [6] = '{C_NONE, C_BUSY, C_BUSY, C_BUSY, C_DONE, C_NONE};
        @(posedge clk); #1; clr_in(); DivStartE = 1;
        push("mr_issue", pk(2'b00, 2'b00, C_NONE));
        @(negedge clk);
        ev = sb_v.pop_front(); en = sb_n.pop_front(); checks++;
        if (act !== ev) begin errors++; $display("FAIL %s: got %b expected %b", en, act, ev); end
        @(posedge clk); #1; DivStartE = 0;
        push("mr_busy", pk(2'b00, 2'b00, C_BUSY));
        @(negedge clk);
        ev = sb_v.pop_front(); en = sb_n.pop_front(); checks++;
        if (act !== ev) begin errors++; $display("FAIL %s: got %b expected %b", en, act, ev); end
        #1;
        ResultSrcE0 = 1; RegWriteE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
        Rs1E = 5; RdM = 5; RegWriteM = 1; reset = 1'b0;
        push("mr_async_drop", pk(FWD ? 2'b10 : 2'b00, 2'b00, C_NONE));
        push("mr_held_low", pk(FWD ? 2'b10 : 2'b00, 2'b00, C_NONE));
        #1;
        ev = sb_v.pop_front(); en = sb_n.pop_front(); checks++;
        if (act !== ev) begin errors++; $display("FAIL %s: got %b expected %b", en, act, ev); end
        @(posedge clk); #1;
        ev = sb_v.pop_front(); en = sb_n.pop_front(); checks++;
        if (act !== ev) begin errors++; $display("FAIL %s: got %b expected %b", en, act, ev); end
        @(negedge clk); #1; clr_in(); reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push("mr_stays_idle", pk(2'b00, 2'b00, C_NONE));
            @(negedge clk);
            ev = sb_v.pop_front(); en = sb_n.pop_front(); checks++;
            if (act !== ev) begin errors++; $display("FAIL %s: got %b expected %b", en, act, ev); end
        end
        for (int i = 0; i < 6; i++) push($sformatf("mr_fresh_c%0d", i), pk(2'b00, 2'b00, seq[i]));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1; clr_in(); DivStartE = (i == 0);
            @(negedge clk);
            ev = sb_v.pop_front(); en = sb_n.pop_front(); checks++;
            if (act !== ev) begin errors++; $display("FAIL %s: got %b expected %b", en, act, ev); end
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_raw_stall();
        test_branch();
        test_back_to_back();
        test_div_hazards();
        test_mid_reset();
        if (sb_v.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_v.size());
        end
        checks++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
